// File: rtl/link_sync_gen.sv
// Link transmit word generator: training burst of sync words, then payload/idle
// slots with one periodic sync word. Optional sync counter under LINK_SYNC_GEN_STATS_EN.
module link_sync_gen #(
  parameter int unsigned           DATA_W      = 8,
  parameter int unsigned           SYNC_PERIOD = 10000,
  parameter int unsigned           TRAIN_LEN   = 16,
  parameter logic [DATA_W-1:0]     SYNC_WORD   = 8'hBC,
  parameter logic [DATA_W-1:0]     IDLE_WORD   = 8'h1C
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic              resync_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_k_o,
  output logic              train_o
`ifdef LINK_SYNC_GEN_STATS_EN
  ,
  output logic [15:0]       sync_count_o
`endif
);

  localparam int unsigned TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_RUN   = 2'd1,
    ST_SYNC  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     train_cnt, train_cnt_n;
  logic [31:0]       period_cnt, period_cnt_n;
  logic [DATA_W-1:0] tx_data_n;
  logic              tx_k_n;
  logic              transfer;

  // Handshake: a word moves only when data_valid_i and data_ready_o are both
  // high in the same cycle; ready is also dropped while reset is asserted so
  // nothing is consumed in a reset cycle.
  assign data_ready_o = (state == ST_RUN) && !resync_i && reset_ni;
  assign transfer     = data_valid_i && data_ready_o;
  assign train_o      = (state == ST_TRAIN);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state      <= ST_TRAIN;
      train_cnt  <= '0;
      period_cnt <= '0;
      tx_data_o  <= SYNC_WORD;
      tx_k_o     <= 1'b1;
    end else begin
      state      <= state_n;
      train_cnt  <= train_cnt_n;
      period_cnt <= period_cnt_n;
      tx_data_o  <= tx_data_n;
      tx_k_o     <= tx_k_n;
    end
  end

  always_comb begin
    state_n      = state;
    train_cnt_n  = train_cnt;
    period_cnt_n = period_cnt;
    if (resync_i) begin
      state_n      = ST_TRAIN;
      train_cnt_n  = '0;
      period_cnt_n = '0;
    end else begin
      case (state)
        ST_TRAIN: begin
          period_cnt_n = '0;
          if (train_cnt == TW'(TRAIN_LEN - 1)) begin
            state_n     = ST_RUN;
            train_cnt_n = '0;
          end else begin
            train_cnt_n = train_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // RUN lasts SYNC_PERIOD-1 cycles so the full period never drifts.
          period_cnt_n = period_cnt + 32'd1;
          if (period_cnt == 32'(SYNC_PERIOD - 2)) state_n = ST_SYNC;
        end
        ST_SYNC: begin
          period_cnt_n = '0;
          state_n      = ST_RUN;
        end
        default: begin
          state_n      = ST_TRAIN;
          train_cnt_n  = '0;
          period_cnt_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    tx_data_n = IDLE_WORD;
    tx_k_n    = 1'b1;
    if (state == ST_TRAIN || state == ST_SYNC) begin
      tx_data_n = SYNC_WORD;
      tx_k_n    = 1'b1;
    end else if (transfer) begin
      tx_data_n = data_i;
      tx_k_n    = 1'b0;
    end
  end

`ifdef LINK_SYNC_GEN_STATS_EN
  // Counts periodic sync slots only; training words are not included.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_count_o <= '0;
    end else if (state == ST_SYNC) begin
      sync_count_o <= sync_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_link_sync_gen.sv
// Directed bench for link_sync_gen (DATA_W=8, SYNC_PERIOD=8, TRAIN_LEN=4).
// Exercises the sync counter too when LINK_SYNC_GEN_STATS_EN is defined.
module tb_link_sync_gen;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] IC = 8'h1C;

  logic       clk_i;
  logic       reset_ni;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic       resync_i;
  logic [7:0] tx_data_o;
  logic       tx_k_o;
  logic       train_o;
`ifdef LINK_SYNC_GEN_STATS_EN
  logic [15:0] sync_count_o;
`endif

  int checks   = 0;
  int failures = 0;

  link_sync_gen #(
    .DATA_W(8), .SYNC_PERIOD(8), .TRAIN_LEN(4),
    .SYNC_WORD(8'hBC), .IDLE_WORD(8'h1C)
  ) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .data_i(data_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .resync_i(resync_i),
    .tx_data_o(tx_data_o),
    .tx_k_o(tx_k_o),
    .train_o(train_o)
`ifdef LINK_SYNC_GEN_STATS_EN
    ,
    .sync_count_o(sync_count_o)
`endif
  );

  // Clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic k);
    check({tag, "_data"}, 32'(tx_data_o), 32'(d));
    check({tag, "_k"}, 32'(tx_k_o), 32'(k));
  endtask

  logic [7:0] d;

  initial begin
    reset_ni     = 1'b0;
    data_valid_i = 1'b1;
    data_i       = 8'h00;
    resync_i     = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check_word("reset", BC, 1'b1);
      check("reset_train", 32'(train_o), 32'd1);
      check("reset_ready", 32'(data_ready_o), 32'd0);
    end

    // Training burst after release
    reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("burst_ready", 32'(data_ready_o), 32'd0);
      tick();
      check_word("burst", BC, 1'b1);
    end
    #1 check("run_ready", 32'(data_ready_o), 32'd1);
    check("run_train", 32'(train_o), 32'd0);

    // Two periods of continuous payload, data incrementing from 0
    d = 8'h00;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 7; j++) begin
        data_i = d;
        #1 check("pay_ready", 32'(data_ready_o), 32'd1);
        tick();
        check_word("payload", d, 1'b0);
        d = d + 8'd1;
      end
      #1 check("sync_ready", 32'(data_ready_o), 32'd0);
      tick();
      check_word("sync", BC, 1'b1);
    end
`ifdef LINK_SYNC_GEN_STATS_EN
    check("stats_two", 32'(sync_count_o), 32'd2);
`endif

    // Idle period: no valid, data_i must not leak out
    data_valid_i = 1'b0;
    data_i       = 8'hAA;
    for (int j = 0; j < 7; j++) begin
      #1 check("idle_ready", 32'(data_ready_o), 32'd1);
      tick();
      check_word("idle", IC, 1'b1);
    end
    #1 check("idle_sync_ready", 32'(data_ready_o), 32'd0);
    tick();
    check_word("idle_sync", BC, 1'b1);

    // Resync pulse at period_cnt = 3
    data_valid_i = 1'b1;
    d = 8'h20;
    for (int j = 0; j < 3; j++) begin
      data_i = d;
      tick();
      check_word("pre_resync", d, 1'b0);
      d = d + 8'd1;
    end
    data_i   = 8'h23;
    resync_i = 1'b1;
    #1 check("resync_ready", 32'(data_ready_o), 32'd0);
    tick();
    check_word("resync_cycle", IC, 1'b1);
    check("resync_train", 32'(train_o), 32'd1);
    resync_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_word("retrain", BC, 1'b1);
    end
    d = 8'h30;
    for (int j = 0; j < 7; j++) begin
      data_i = d;
      #1 check("post_ready", 32'(data_ready_o), 32'd1);
      tick();
      check_word("post_payload", d, 1'b0);
      d = d + 8'd1;
    end
    #1 check("post_sync_ready", 32'(data_ready_o), 32'd0);
    tick();
    check_word("post_sync", BC, 1'b1);

    // Reset in the middle of RUN, then resync held for six cycles in TRAIN
    d = 8'h40;
    for (int j = 0; j < 2; j++) begin
      data_i = d;
      tick();
      check_word("pre_reset", d, 1'b0);
      d = d + 8'd1;
    end
    data_i   = 8'h42;
    reset_ni = 1'b0;
    #1 check("midreset_ready", 32'(data_ready_o), 32'd0);
    tick();
    check_word("midreset", BC, 1'b1);
    check("midreset_train", 32'(train_o), 32'd1);
`ifdef LINK_SYNC_GEN_STATS_EN
    check("stats_clear", 32'(sync_count_o), 32'd0);
`endif
    reset_ni = 1'b1;
    resync_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check("hold_ready", 32'(data_ready_o), 32'd0);
      check("hold_train", 32'(train_o), 32'd1);
      tick();
      check_word("hold", BC, 1'b1);
    end
    resync_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("tail_ready", 32'(data_ready_o), 32'd0);
      check("tail_train", 32'(train_o), 32'd1);
      tick();
      check_word("tail", BC, 1'b1);
    end
    data_i = 8'h50;
    #1 check("final_ready", 32'(data_ready_o), 32'd1);
    check("final_train", 32'(train_o), 32'd0);
    tick();
    check_word("final", 8'h50, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
